coin_report_tx: RTL and testbench

COIN_REPORT_TX -- requirements
Module: coin_report_tx

---
 rtl/piggy_pkg.sv | 47 ++++
 rtl/uart_byte_tx.sv | 84 ++++++++
 rtl/coin_report_tx.sv | 117 +++++++++++
 tb/tb_coin_report_tx.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/piggy_pkg.sv
// piggy_pkg: shared constants, sequencer state type and frame-byte helper
// for the coin report transmitter.
//   ASCII_COMMA/CR/LF : separator and line-terminator bytes
//   FRAME_LEN         : bytes per report frame
//   state_e           : frame sequencer states
//   frame_byte()      : selects byte idx of a frame from the packed digit snapshot
package piggy_pkg;

  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam int         FRAME_LEN   = 17;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_NEXT
  } state_e;

  // digits = {ten, five, two, one}, each three ASCII bytes MSB first.
  function automatic logic [7:0] frame_byte(input logic [95:0] digits,
                                            input logic [4:0]  idx);
    logic [7:0] b;
    case (idx)
      5'd0:                b = digits[95:88];
      5'd1:                b = digits[87:80];
      5'd2:                b = digits[79:72];
      5'd4:                b = digits[71:64];
      5'd5:                b = digits[63:56];
      5'd6:                b = digits[55:48];
      5'd8:                b = digits[47:40];
      5'd9:                b = digits[39:32];
      5'd10:               b = digits[31:24];
      5'd12:               b = digits[23:16];
      5'd13:               b = digits[15:8];
      5'd14:               b = digits[7:0];
      5'd3, 5'd7, 5'd11:   b = ASCII_COMMA;
      5'd15:               b = ASCII_CR;
      default:             b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1 serializer for one byte at a time.
//   clk, rst_n      : clock, synchronous active-low reset
//   valid_i/data_i  : byte offered; taken when ready_o is high
//   ready_o         : idle, or in the final cycle of the stop bit (allows
//                     back-to-back bytes with no idle gap)
//   serial_o        : UART line, idle high
//   bit_end_o       : last cycle of the current bit period
//   data_last_o     : last cycle of data bit 7
//   stop_pre_end_o  : cycle before the final stop-bit cycle
module uart_byte_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       valid_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       serial_o,
  output logic       bit_end_o,
  output logic       data_last_o,
  output logic       stop_pre_end_o
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;   // 0 start, 1..8 data, 9 stop
  logic [9:0]    sh_q, sh_d;     // {stop, data, start}, shifted out LSB first
  logic          accept, byte_end;

  assign bit_end_o      = busy_q && (cnt_q == CNT_MAX);
  assign byte_end       = bit_end_o && (bit_q == 4'd9);
  assign data_last_o    = bit_end_o && (bit_q == 4'd8);
  assign stop_pre_end_o = busy_q && (bit_q == 4'd9) && (cnt_q == CNT_PRE);
  assign ready_o        = !busy_q || byte_end;
  assign accept         = valid_i && ready_o;
  assign serial_o       = busy_q ? sh_q[0] : 1'b1;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    bit_d  = bit_q;
    sh_d   = sh_q;
    if (accept) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      bit_d  = '0;
      sh_d   = {1'b1, data_i, 1'b0};
    end else if (busy_q) begin
      if (bit_end_o) begin
        cnt_d = '0;
        if (byte_end) begin
          busy_d = 1'b0;
        end else begin
          bit_d = bit_q + 4'd1;
          sh_d  = {1'b1, sh_q[9:1]};
        end
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      bit_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      bit_q  <= bit_d;
    end
  end

  // Shift data needs no reset: serial_o is forced high while not busy.
  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

endmodule

// File: rtl/coin_report_tx.sv
// coin_report_tx: sends a 17-byte coin-count report "ttt,fff,www,ooo\r\n"
// over UART (8N1), bytes back-to-back.
//   clk, rst_n        : clock, synchronous active-low reset
//   start_sending     : request one frame; requests while busy are merged
//                       into a single pending frame
//   tenbaht..onebaht  : three ASCII digits each, snapshotted at frame start
//   o_Tx_Active       : high from first start bit to last stop bit
//   o_Tx_Done         : one-cycle pulse after a frame's last stop bit
//   o_Tx_Serial       : UART line, idle high
//   o_busy            : frame in progress or request pending
module coin_report_tx #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_sending,
  input  logic [23:0] tenbaht,
  input  logic [23:0] fivebaht,
  input  logic [23:0] twobaht,
  input  logic [23:0] onebaht,
  output logic        o_Tx_Active,
  output logic        o_Tx_Done,
  output logic        o_Tx_Serial,
  output logic        o_busy
);
  import piggy_pkg::*;

  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  state_e      state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        pend_q, pend_d;
  logic        done_q, done_d;
  logic [95:0] snap_q;

  logic        tx_valid, tx_ready, tx_bit_end, tx_data_last, tx_stop_pre_end;
  logic [7:0]  tx_data;

  uart_byte_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte_tx (
    .clk            (clk),
    .rst_n          (rst_n),
    .valid_i        (tx_valid),
    .data_i         (tx_data),
    .ready_o        (tx_ready),
    .serial_o       (o_Tx_Serial),
    .bit_end_o      (tx_bit_end),
    .data_last_o    (tx_data_last),
    .stop_pre_end_o (tx_stop_pre_end)
  );

  // The sequencer tracks the serializer's bit phases in lock-step. NEXT is
  // the final cycle of each stop bit, so the following byte is handed over
  // while the stop bit is still on the line and no idle gap appears.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pend_d   = pend_q;
    tx_valid = 1'b0;
    tx_data  = frame_byte(snap_q, idx_q + 5'd1);
    done_d   = (state_q == ST_NEXT) && (idx_q == LAST_IDX);

    if (start_sending && (state_q != ST_IDLE)) pend_d = 1'b1;

    case (state_q)
      ST_IDLE: if (start_sending) state_d = ST_LOAD;
      ST_LOAD: begin
        // Byte 0 comes straight from the inputs being snapshotted this cycle.
        tx_valid = 1'b1;
        tx_data  = tenbaht[23:16];
        idx_d    = '0;
        if (tx_ready) state_d = ST_START;
      end
      ST_START: if (tx_bit_end)      state_d = ST_DATA;
      ST_DATA:  if (tx_data_last)    state_d = ST_STOP;
      ST_STOP:  if (tx_stop_pre_end) state_d = ST_NEXT;
      ST_NEXT: begin
        if (idx_q < LAST_IDX) begin
          tx_valid = 1'b1;
          if (tx_ready) begin
            idx_d   = idx_q + 5'd1;
            state_d = ST_START;
          end
        end else if (pend_q || start_sending) begin
          pend_d  = 1'b0;
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == ST_LOAD) snap_q <= {tenbaht, fivebaht, twobaht, onebaht};
  end

  assign o_Tx_Active = (state_q == ST_START) || (state_q == ST_DATA) ||
                       (state_q == ST_STOP)  || (state_q == ST_NEXT);
  assign o_Tx_Done   = done_q;
  assign o_busy      = (state_q != ST_IDLE) || pend_q;

endmodule

// File: tb/tb_coin_report_tx.sv
module tb_coin_report_tx;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_sending = 1'b0;
  logic [23:0] tenbaht, fivebaht, twobaht, onebaht;
  logic        o_Tx_Active, o_Tx_Done, o_Tx_Serial, o_busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc[$];
  logic [7:0] exp_q[$];

  coin_report_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_sending (start_sending),
    .tenbaht       (tenbaht),
    .fivebaht      (fivebaht),
    .twobaht       (twobaht),
    .onebaht       (onebaht),
    .o_Tx_Active   (o_Tx_Active),
    .o_Tx_Done     (o_Tx_Done),
    .o_Tx_Serial   (o_Tx_Serial),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected frame built from the inputs present when the frame goes active.
  task automatic push_frame();
    logic [7:0] f[17];
    f = '{tenbaht[23:16], tenbaht[15:8], tenbaht[7:0], 8'h2C,
          fivebaht[23:16], fivebaht[15:8], fivebaht[7:0], 8'h2C,
          twobaht[23:16], twobaht[15:8], twobaht[7:0], 8'h2C,
          onebaht[23:16], onebaht[15:8], onebaht[7:0], 8'h0D, 8'h0A};
    foreach (f[i]) exp_q.push_back(f[i]);
  endtask

  // Frame tracker: pushes expectations, measures active length, done placement.
  initial begin : tracker
    logic prev_act;
    logic aborted;
    int   run;
    prev_act = 1'b0;
    aborted  = 1'b0;
    run      = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) aborted = 1'b1;
      if (o_Tx_Active === 1'b1 && !prev_act) begin
        push_frame();
        run     = 1;
        aborted = !rst_n;
      end else if (o_Tx_Active === 1'b1) begin
        run++;
      end else if (prev_act) begin
        if (aborted) begin
          check("abort_no_done", o_Tx_Done, 1'b0);
        end else begin
          check("active_len", run, 680);
          check("done_at_end", o_Tx_Done, 1'b1);
          check("line_high_between", o_Tx_Serial, 1'b1);
        end
      end
      if (o_Tx_Done === 1'b1) begin
        check("done_placement", prev_act && (o_Tx_Active === 1'b0), 1'b1);
        done_cnt++;
        done_cyc.push_back(cyc);
      end
      prev_act = (o_Tx_Active === 1'b1);
    end
  end

  // UART receiver: every bit must be steady for exactly CPB cycles.
  initial begin : monitor
    logic [9:0] bits;
    logic steady, lost, v;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && o_Tx_Serial === 1'b0) begin
        steady = 1'b1;
        lost   = 1'b0;
        bits   = '0;
        v      = 1'b0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < CPB; c++) begin
            if (b != 0 || c != 0) @(negedge clk);
            if (!rst_n) lost = 1'b1;
            if (c == 0) v = o_Tx_Serial;
            else if (o_Tx_Serial !== v) steady = 1'b0;
          end
          bits[b] = v;
        end
        if (!lost) begin
          check("bit_timing", {steady, bits[0], bits[9]}, 3'b101);
          check("byte_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rx_byte", bits[8:1], e);
          end
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse();
    start_sending = 1'b1;
    step(1);
    start_sending = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, done_cnt >= target, 1'b1);
  endtask

  initial begin : stim
    logic [9:0] pat;
    int base;
    int k;
    pat = 10'b1001100000;  // start, 0x30 LSB first, stop

    tenbaht = "012"; fivebaht = "005"; twobaht = "100"; onebaht = "255";

    // Reset with a request that must be ignored
    rst_n = 1'b0;
    start_sending = 1'b1;
    step(3);
    @(negedge clk);
    check("rst_serial", o_Tx_Serial, 1'b1);
    check("rst_active", o_Tx_Active, 1'b0);
    check("rst_done", o_Tx_Done, 1'b0);
    check("rst_busy", o_busy, 1'b0);
    step(1);
    rst_n = 1'b1;
    start_sending = 1'b0;
    step(2);
    @(negedge clk);
    check("idle_after_rst", o_busy, 1'b0);

    // Basic frame, latency and first-byte line pattern
    step(1);
    pulse();
    @(negedge clk);
    check("lat_load_serial", o_Tx_Serial, 1'b1);
    check("lat_load_active", o_Tx_Active, 1'b0);
    check("lat_load_busy", o_busy, 1'b1);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      check("byte0_line", o_Tx_Serial, pat[i / CPB]);
      if (i == 0) check("lat_active", o_Tx_Active, 1'b1);
    end
    wait_done("frame1_done", 1, 800);
    step(2);
    check("frame1_bytes", exp_q.size(), 0);

    // Input change mid-frame must not leak into the frame in flight
    pulse();
    step(2 + 5 * 40);
    tenbaht = "999";
    wait_done("frame2_done", 2, 800);
    check("frame2_done_cnt", done_cnt, 2);
    step(2);
    pulse();
    wait_done("frame3_done", 3, 800);
    step(2);
    check("snapshot_bytes", exp_q.size(), 0);

    // Three extra requests during one frame merge into one pending frame
    base = done_cnt;
    pulse();
    step(50);  pulse();
    step(100); pulse();
    step(100); pulse();
    @(negedge clk);
    check("busy_pending", o_busy, 1'b1);
    wait_done("merge_first", base + 1, 800);
    check("busy_between", o_busy, 1'b1);
    wait_done("merge_second", base + 2, 800);
    @(negedge clk);
    check("busy_after_second", o_busy, 1'b0);
    step(800);
    check("no_third_frame", done_cnt, base + 2);
    check("merge_bytes", exp_q.size(), 0);

    // Reset in the middle of byte 8
    base = done_cnt;
    pulse();
    step(2 + 8 * 40 + 13);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_serial", o_Tx_Serial, 1'b1);
    check("abort_active", o_Tx_Active, 1'b0);
    check("abort_done", o_Tx_Done, 1'b0);
    step(60);
    check("abort_no_done_cnt", done_cnt, base);
    exp_q.delete();
    pulse();
    wait_done("after_abort_done", base + 1, 800);
    step(2);
    check("after_abort_bytes", exp_q.size(), 0);

    // Request held high: back-to-back frames at a fixed period
    tenbaht = "123"; fivebaht = "456"; twobaht = "789"; onebaht = "000";
    done_cyc.delete();
    start_sending = 1'b1;
    step(2000);
    start_sending = 1'b0;
    k = 0;
    while (o_busy !== 1'b0 && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check("held_drain", o_busy, 1'b0);
    check("held_frames", done_cyc.size() >= 3, 1'b1);
    for (int i = 1; i < done_cyc.size(); i++)
      check("done_period", done_cyc[i] - done_cyc[i - 1], 681);
    step(2);
    check("held_bytes", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
